step_clock_ctrl: RTL and testbench

Parametrised execution-clock controller for the board-level pipeline CPU. It debounces the front-panel `button` and issues single-cycle `step_en` clock-enable pulses in the `clk` domain. Mode is selectable: single step, N-step burst, or free run with a programmable divider. It also keeps a wrapping tick count for the seven-segment display. It replaces ad-hoc derived step clocks, so every CPU register stays on `clk` and is gated by `step_en`.

---
 rtl/step_ctrl_pkg.sv | 20 ++
 rtl/button_debounce.sv | 65 ++++++
 rtl/step_clock_ctrl.sv | 133 +++++++++++++
 tb/tb_step_clock_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_ctrl_pkg.sv
// Shared types for the step clock controller.
//   step_mode_t  : operator-selected mode, sampled when a press is accepted
//   step_state_t : controller FSM state
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_STEP  = 2'b00,
    MODE_BURST = 2'b01,
    MODE_RUN   = 2'b10,
    MODE_HOLD  = 2'b11
  } step_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    STEP  = 2'b01,
    BURST = 2'b10,
    RUN   = 2'b11
  } step_state_t;

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, and a
// one-cycle press pulse on each debounced rising edge.
//   clk, reset : clock, async active-high reset
//   button     : raw asynchronous button level
//   press      : one-cycle pulse per accepted press (registered)
//   stable     : debounced button level
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 5000
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic press,
  output logic stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
    $error("DEBOUNCE_CYCLES must be >= 1");
  end

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             stable_prev_q, stable_prev_d;
  logic             press_q, press_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q        <= '0;
      cnt_q         <= '0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      press_q       <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      cnt_q         <= cnt_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      press_q       <= press_d;
    end
  end

  always_comb begin
    sync_d        = {sync_q[0], button};
    // Counter only advances while the synchronized level disagrees with the
    // accepted level; any agreement restarts the qualification window.
    cnt_d         = '0;
    stable_d      = stable_q;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_LAST) stable_d = sync_q[1];
      else                   cnt_d    = cnt_q + 1'b1;
    end
    stable_prev_d = stable_q;
    // Edge detect on the registered level, so press lands one cycle after
    // stable rises; a held button can only produce one press.
    press_d       = stable_q & ~stable_prev_q;
  end

  assign press  = press_q;
  assign stable = stable_q;

endmodule

// File: rtl/step_clock_ctrl.sv
// Execution-clock controller for the pipeline CPU. Turns debounced button
// presses into single-cycle step_en clock-enable pulses in single-step,
// N-step burst or free-run mode, and counts issued pulses.
//   clk, reset : clock, async active-high reset
//   button     : raw push-button level
//   mode       : 00 step, 01 burst, 10 run, 11 hold
//   burst_len  : pulse count for burst mode
//   halt       : synchronous stop request (level)
//   step_en    : registered one-cycle CPU clock enable
//   busy       : FSM not IDLE
//   ticks      : wrapping count of issued step_en pulses
module step_clock_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 5000,
  parameter int RUN_DIV         = 50000,
  parameter int BURST_W         = 8,
  parameter int TICK_W          = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               button,
  input  logic [1:0]         mode,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               halt,
  output logic               step_en,
  output logic               busy,
  output logic [TICK_W-1:0]  ticks
);

  localparam int DIV_W = $clog2(RUN_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(RUN_DIV - 1);

  if (RUN_DIV < 1) begin : g_bad_div
    $error("RUN_DIV must be >= 1");
  end

  logic press;
  logic unused_stable;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .reset (reset),
    .button(button),
    .press (press),
    .stable(unused_stable)
  );

  step_state_t        state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic               step_en_q, step_en_d;
  logic [TICK_W-1:0]  ticks_q, ticks_d;
  logic               abort;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      rem_q     <= '0;
      step_en_q <= 1'b0;
      ticks_q   <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      rem_q     <= rem_d;
      step_en_q <= step_en_d;
      ticks_q   <= ticks_d;
    end
  end

  // Next state. The register contents describe the current cycle: in an
  // active state a pulse is on step_en exactly when div_q is 0.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    rem_d   = rem_q;
    abort   = press | halt;
    case (state_q)
      IDLE: begin
        if (press && !halt) begin
          // First pulse lands in the very next cycle for every mode.
          div_d = '0;
          case (step_mode_t'(mode))
            MODE_STEP:  state_d = STEP;
            MODE_BURST: begin
              if (burst_len != '0) begin
                state_d = BURST;
                rem_d   = burst_len;
              end
            end
            MODE_RUN:   state_d = RUN;
            default:    ;
          endcase
        end
      end
      STEP: state_d = IDLE;
      BURST: begin
        // Abort is evaluated first so it also cancels the next due pulse.
        if (abort) begin
          state_d = IDLE;
        end else if (div_q == '0) begin
          rem_d = rem_q - 1'b1;
          div_d = DIV_RELOAD;
          if (rem_q == BURST_W'(1)) state_d = IDLE;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      RUN: begin
        if (abort)              state_d = IDLE;
        else if (div_q == '0)   div_d   = DIV_RELOAD;
        else                    div_d   = div_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs. step_en is registered from the next-state view so it is high
  // in exactly the cycles where the FSM is active with a zero divider.
  always_comb begin
    step_en_d = (state_d != IDLE) && (div_d == '0);
    ticks_d   = ticks_q + TICK_W'(step_en_q);
    busy      = (state_q != IDLE);
  end

  assign step_en = step_en_q;
  assign ticks   = ticks_q;

endmodule

// File: tb/tb_step_clock_ctrl.sv
module tb_step_clock_ctrl;

  localparam int DC = 4;
  localparam int RD = 3;
  localparam int TW = 4;
  localparam int BW = 8;

  localparam int K_NONE  = 0;
  localparam int K_STEP  = 1;
  localparam int K_BURST = 2;
  localparam int K_RUN   = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          button;
  logic [1:0]    mode;
  logic [BW-1:0] burst_len;
  logic          halt;
  logic          step_en;
  logic          busy;
  logic [TW-1:0] ticks;

  step_clock_ctrl #(
    .DEBOUNCE_CYCLES(DC),
    .RUN_DIV        (RD),
    .BURST_W        (BW),
    .TICK_W         (TW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .button   (button),
    .mode     (mode),
    .burst_len(burst_len),
    .halt     (halt),
    .step_en  (step_en),
    .busy     (busy),
    .ticks    (ticks)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;

  // Reference model: pulses are scheduled by absolute edge number
  // (start + k*RD) rather than by a divider.
  int m_cyc, m_kind, m_start, m_left, m_run, m_ticks;
  bit m_step, m_stable, m_rose, m_press, smp0, smp1;

  typedef struct {
    logic [1:0]    mode;
    logic [BW-1:0] len;
    int            exp_pulses;
    int            exp_ticks;
  } row_t;

  row_t rows[6];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_kind = K_NONE; m_start = 0; m_left = 0; m_run = 0;
    m_ticks = 0; m_step = 0; m_stable = 0; m_rose = 0; m_press = 0;
    smp0 = 0; smp1 = 0;
  endtask

  task automatic model_edge();
    bit synced;
    if (reset) begin
      model_reset();
      return;
    end
    m_cyc++;
    m_ticks = (m_ticks + int'(m_step)) % (1 << TW);
    if (m_kind == K_NONE) begin
      if (m_press && !halt) begin
        m_start = m_cyc;
        case (mode)
          2'd0: m_kind = K_STEP;
          2'd1: if (burst_len != 0) begin m_kind = K_BURST; m_left = int'(burst_len); end
          2'd2: m_kind = K_RUN;
          default: ;
        endcase
      end
    end else if (m_kind == K_STEP || m_press || halt) begin
      m_kind = K_NONE;
    end else if (m_kind == K_BURST && m_step) begin
      m_left--;
      if (m_left == 0) m_kind = K_NONE;
    end
    m_step  = (m_kind != K_NONE) && (((m_cyc - m_start) % RD) == 0);
    // press appears two edges after the debounced level rises
    m_press = m_rose;
    m_rose  = 0;
    synced  = smp1;
    if (synced != m_stable) begin
      m_run++;
      if (m_run == DC) begin
        m_stable = synced;
        m_run    = 0;
        m_rose   = synced;
      end
    end else begin
      m_run = 0;
    end
    smp1 = smp0;
    smp0 = button;
  endtask

  // One clock: model advances on the edge, DUT is compared mid-cycle.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("model", int'({ticks, busy, step_en}),
          m_ticks * 4 + int'(m_kind != K_NONE) * 2 + int'(m_step));
    if (step_en === 1'b1) pulses++;
  endtask

  task automatic press_btn(input int hold, input int rel);
    button = 1'b1;
    repeat (hold) tick();
    button = 1'b0;
    repeat (rel) tick();
  endtask

  task automatic wait_pulse(input string name, input int max);
    int k;
    k = 0;
    while (step_en !== 1'b1 && k < max) begin
      tick();
      k++;
    end
    check({name, " reached"}, int'(step_en === 1'b1), 1);
  endtask

  initial begin
    int p0, first, sm, bm;

    rows[0] = '{2'd0, 8'd0, 1, 2};
    rows[1] = '{2'd1, 8'd5, 5, 7};
    rows[2] = '{2'd1, 8'd0, 0, 7};
    rows[3] = '{2'd1, 8'd1, 1, 8};
    rows[4] = '{2'd3, 8'd3, 0, 8};
    rows[5] = '{2'd1, 8'd3, 3, 11};

    reset = 1'b1; button = 1'b0; mode = 2'd0; burst_len = '0; halt = 1'b0;
    model_reset();
    #3;
    check("reset step_en", int'(step_en), 0);
    check("reset busy", int'(busy), 0);
    check("reset ticks", int'(ticks), 0);
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;

    // Single step with a long hold: one pulse, 7 cycles after first sample.
    mode   = 2'd0;
    p0     = pulses;
    first  = -1;
    button = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      tick();
      if (step_en === 1'b1 && first < 0) first = j - 1;
    end
    button = 1'b0;
    repeat (12) tick();
    check("step latency", first, 7);
    check("step count", pulses - p0, 1);
    check("step ticks", int'(ticks), 1);

    // Glitchy button never qualifies.
    p0 = pulses;
    repeat (5) begin
      button = 1'b1;
      repeat (3) tick();
      button = 1'b0;
      tick();
    end
    repeat (10) tick();
    check("glitch pulses", pulses - p0, 0);
    check("glitch ticks", int'(ticks), 1);

    // Table: one press per mode/length, count pulses in a fixed window.
    foreach (rows[i]) begin
      mode      = rows[i].mode;
      burst_len = rows[i].len;
      p0        = pulses;
      press_btn(8, 32);
      check($sformatf("row%0d pulses", i), pulses - p0, rows[i].exp_pulses);
      check($sformatf("row%0d ticks", i), int'(ticks), rows[i].exp_ticks);
      check($sformatf("row%0d busy", i), int'(busy), 0);
    end

    // Burst of 5: exact pulse spacing and busy window.
    mode      = 2'd1;
    burst_len = 8'd5;
    button    = 1'b1;
    wait_pulse("burst5 start", 20);
    sm = 0;
    bm = 0;
    for (int k = 0; k < 16; k++) begin
      sm |= int'(step_en === 1'b1) << k;
      bm |= int'(busy === 1'b1) << k;
      if (k == 2) button = 1'b0;
      tick();
    end
    check("burst5 pulse map", sm, 32'h1249);
    check("burst5 busy map", bm, 32'h1FFF);

    // Free run, then halt in the cycle before a due pulse.
    mode   = 2'd2;
    button = 1'b1;
    wait_pulse("run start", 20);
    button = 1'b0;
    repeat (60) tick();
    wait_pulse("run pulse", 5);
    tick();
    tick();
    halt = 1'b1;
    tick();
    check("halt suppress", int'(step_en), 0);
    check("halt busy", int'(busy), 0);
    halt = 1'b0;
    repeat (6) tick();
    check("halt stays idle", int'(busy), 0);

    // Run, change mode mid-run (ignored), second press stops it.
    mode   = 2'd2;
    button = 1'b1;
    wait_pulse("run2 start", 20);
    button = 1'b0;
    repeat (10) tick();
    mode = 2'd0;
    p0   = pulses;
    repeat (9) tick();
    check("mode change ignored", pulses - p0, 3);
    press_btn(8, 12);
    p0 = pulses;
    repeat (20) tick();
    check("press stop busy", int'(busy), 0);
    check("press stop pulses", pulses - p0, 0);

    // Asynchronous reset in the middle of a burst.
    mode      = 2'd1;
    burst_len = 8'd9;
    button    = 1'b1;
    wait_pulse("burst9 start", 20);
    button = 1'b0;
    repeat (4) tick();
    check("pre-reset busy", int'(busy), 1);
    reset = 1'b1;
    #1;
    check("async rst step_en", int'(step_en), 0);
    check("async rst busy", int'(busy), 0);
    check("async rst ticks", int'(ticks), 0);
    model_reset();
    @(negedge clk);
    tick();
    reset = 1'b0;
    mode  = 2'd0;
    p0    = pulses;
    press_btn(8, 14);
    check("post-reset pulses", pulses - p0, 1);
    check("post-reset ticks", int'(ticks), 1);

    // Randomized traffic against the model.
    for (int s = 0; s < 200; s++) begin
      button = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
      burst_len = BW'($urandom_range(0, 6));
      repeat ($urandom_range(1, 14)) begin
        halt = ($urandom_range(0, 19) == 0);
        tick();
      end
    end
    halt = 1'b0;
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
